// File: rtl/serial_word_collector.sv
// Serial-to-parallel receive stage: gathers MSB-first bits into WIDTH-bit words
// and queues them in a first-word-fall-through FIFO with a valid/ready output.
module serial_word_collector #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 4,
  parameter int REQUIRE_FRAME = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_bit_valid,
  input  logic                     i_bit,
  input  logic                     i_frame,
  output logic [WIDTH-1:0]         o_word,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  input  logic                     i_clear_ovf,
  output logic                     o_frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  acc, acc_n, shifted;
  logic [CW-1:0]     bit_cnt, bit_cnt_n;
  logic              push, frame_err_n;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, empty, pop, do_push, ovf_set;

  assign shifted = {acc[WIDTH-2:0], i_bit};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= (REQUIRE_FRAME != 0) ? HUNT : COLLECT;
      acc         <= '0;
      bit_cnt     <= '0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      bit_cnt     <= bit_cnt_n;
      o_frame_err <= frame_err_n;
    end
  end

  // A framed bit always restarts the word; it only counts as an error when it
  // throws away bits already gathered.
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    bit_cnt_n   = bit_cnt;
    push        = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      HUNT: begin
        if (i_bit_valid && i_frame) begin
          acc_n     = WIDTH'(i_bit);
          bit_cnt_n = CW'(1);
          state_n   = COLLECT;
        end
      end
      COLLECT: begin
        if (i_bit_valid) begin
          if (i_frame && bit_cnt != '0) begin
            frame_err_n = 1'b1;
            acc_n       = WIDTH'(i_bit);
            bit_cnt_n   = CW'(1);
          end else if (bit_cnt == LAST_BIT) begin
            acc_n     = shifted;
            push      = 1'b1;
            bit_cnt_n = '0;
          end else begin
            acc_n     = shifted;
            bit_cnt_n = bit_cnt + CW'(1);
          end
        end
      end
    endcase
  end

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign pop     = i_ready && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shifted;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (ovf_set)          o_overflow <= 1'b1;
      else if (i_clear_ovf) o_overflow <= 1'b0;
    end
  end

  assign o_valid = !empty;
  assign o_word  = empty ? '0 : mem[rd_ptr];
  assign o_count = count;

endmodule

// File: tb/tb_serial_word_collector.sv
// Self-checking bench for serial_word_collector (WIDTH=8, DEPTH=4): directed
// vector table, hand-written corner sequences, and random traffic vs a queue model.
module tb_serial_word_collector;

  localparam int W = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bit_valid = 1'b0, bit_in = 1'b0, frame = 1'b0, ready = 1'b0, clear_ovf = 1'b0;
  logic [7:0] word1, word0;
  logic       valid1, valid0, ovf1, ovf0, err1, err0;
  logic [2:0] count1, count0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_word_collector #(.WIDTH(W), .DEPTH(D), .REQUIRE_FRAME(1)) dut (
    .i_clk(clk), .i_reset(reset), .i_bit_valid(bit_valid), .i_bit(bit_in), .i_frame(frame),
    .o_word(word1), .o_valid(valid1), .i_ready(ready), .o_count(count1),
    .o_overflow(ovf1), .i_clear_ovf(clear_ovf), .o_frame_err(err1));

  serial_word_collector #(.WIDTH(W), .DEPTH(D), .REQUIRE_FRAME(0)) dut_nf (
    .i_clk(clk), .i_reset(reset), .i_bit_valid(bit_valid), .i_bit(bit_in), .i_frame(frame),
    .o_word(word0), .o_valid(valid0), .i_ready(ready), .o_count(count0),
    .o_overflow(ovf0), .i_clear_ovf(clear_ovf), .o_frame_err(err0));

  typedef struct {
    logic bv, b, fr, rdy, clr;
    logic ev; logic [7:0] ew; logic [2:0] ec; logic eo, ee;
  } vec_t;
  vec_t vecs[$];

  // Reference model: bits gathered so far, queued words, and sticky flags.
  bit         m_hunting;
  bit         m_bits[$];
  logic [7:0] m_fifo[$];
  bit         m_ovf, m_err;

  function automatic vec_t mk(logic bv, logic b, logic fr, logic rdy, logic clr,
                              logic ev, logic [7:0] ew, logic [2:0] ec, logic eo, logic ee);
    vec_t v;
    v.bv = bv; v.b = b; v.fr = fr; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ew = ew; v.ec = ec; v.eo = eo; v.ee = ee;
    return v;
  endfunction

  task automatic modelReset();
    m_hunting = 1'b1;
    m_bits.delete();
    m_fifo.delete();
    m_ovf = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic modelStep(input logic bv, input logic b, input logic fr, input logic rdy, input logic clr);
    bit         push_now = 1'b0;
    bit         was_full = (m_fifo.size() == D);
    bit         popped   = (m_fifo.size() > 0) && rdy;
    logic [7:0] w = '0;
    m_err = 1'b0;
    if (bv) begin
      if (m_hunting) begin
        if (fr) begin
          m_bits.delete(); m_bits.push_back(b); m_hunting = 1'b0;
        end
      end else if (fr && m_bits.size() > 0) begin
        m_err = 1'b1;
        m_bits.delete(); m_bits.push_back(b);
      end else begin
        m_bits.push_back(b);
        if (m_bits.size() == W) begin
          foreach (m_bits[i]) w = {w[6:0], m_bits[i]};
          push_now = 1'b1;
          m_bits.delete();
        end
      end
    end
    if (popped) void'(m_fifo.pop_front());
    if (push_now) begin
      if (was_full && !popped) m_ovf = 1'b1;
      else m_fifo.push_back(w);
    end else if (clr) m_ovf = 1'b0;
    if (push_now && was_full && !popped) m_ovf = 1'b1;
    else if (clr && push_now) m_ovf = 1'b0;
  endtask

  task automatic applyStimulus(input logic bv, input logic b, input logic fr, input logic rdy, input logic clr);
    bit_valid = bv; bit_in = b; frame = fr; ready = rdy; clear_ovf = clr;
    @(posedge clk);
    #1;
    modelStep(bv, b, fr, rdy, clr);
    bit_valid = 1'b0; bit_in = 1'b0; frame = 1'b0; ready = 1'b0; clear_ovf = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [7:0] ew,
                             input logic [2:0] ec, input logic eo, input logic ee);
    tests++;
    if (valid1 !== ev || word1 !== ew || count1 !== ec || ovf1 !== eo || err1 !== ee) begin
      fails++;
      $display("[TB] FAIL %s: got valid=%0b word=%02h count=%0d ovf=%0b err=%0b, expected valid=%0b word=%02h count=%0d ovf=%0b err=%0b",
               name, valid1, word1, count1, ovf1, err1, ev, ew, ec, eo, ee);
    end
  endtask

  task automatic checkNoFrame(input string name, input logic ev, input logic [7:0] ew, input logic [2:0] ec);
    tests++;
    if (valid0 !== ev || word0 !== ew || count0 !== ec) begin
      fails++;
      $display("[TB] FAIL %s: got valid=%0b word=%02h count=%0d, expected valid=%0b word=%02h count=%0d",
               name, valid0, word0, count0, ev, ew, ec);
    end
  endtask

  task automatic doReset();
    bit_valid = 1'b0; bit_in = 1'b0; frame = 1'b0; ready = 1'b0; clear_ovf = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  task automatic sendWord(input logic [7:0] w, input logic use_frame, input logic rdy_last);
    for (int i = 7; i >= 0; i--)
      applyStimulus(1'b1, w[i], use_frame && (i == 7), (i == 0) ? rdy_last : 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] ew;
    modelReset();
    doReset();
    checkOutput("reset_state", 0, 8'h00, 3'd0, 0, 0);
    checkNoFrame("reset_state_nf", 0, 8'h00, 3'd0);

    // Table: ignored frame-without-valid, framed 0xA5, pop, pop-while-empty.
    pat = 8'hA5;
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00, 3'd0, 0, 0));
    for (int i = 7; i >= 0; i--)
      vecs.push_back(mk(1, pat[i], i == 7, 0, 0, i == 0, (i == 0) ? 8'hA5 : 8'h00, (i == 0) ? 3'd1 : 3'd0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 8'h00, 3'd0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 8'h00, 3'd0, 0, 0));
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].bv, vecs[i].b, vecs[i].fr, vecs[i].rdy, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ew, vecs[i].ec, vecs[i].eo, vecs[i].ee);
    end

    // Unframed bits are ignored while hunting, collected at once without framing.
    doReset();
    sendWord(8'hFF, 1'b0, 1'b0);
    checkOutput("hunt_ignores", 0, 8'h00, 3'd0, 0, 0);
    checkNoFrame("noframe_collects", 1, 8'hFF, 3'd1);
    sendWord(8'h3C, 1'b1, 1'b0);
    checkOutput("hunt_then_frame", 1, 8'h3C, 3'd1, 0, 0);

    // Overflow on the fifth word, ordered drain, then clear.
    doReset();
    for (int k = 1; k <= 5; k++) sendWord(8'(k), 1'b1, 1'b0);
    checkOutput("overflow_full", 1, 8'h01, 3'd4, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(0, 0, 0, 1, 0);
      ew = (k < 4) ? 8'(k + 1) : 8'h00;
      checkOutput($sformatf("drain%0d", k), k < 4, ew, 3'(4 - k), 1, 0);
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("clear_ovf", 0, 8'h00, 3'd0, 0, 0);

    // Frame arriving mid-word.
    doReset();
    applyStimulus(1, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    pat = 8'h5A;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1, pat[i], i == 7, 0, 0);
      if (i == 7) checkOutput("frame_err_pulse", 0, 8'h00, 3'd0, 0, 1);
      if (i == 6) checkOutput("frame_err_one_cycle", 0, 8'h00, 3'd0, 0, 0);
    end
    checkOutput("frame_err_word", 1, 8'h5A, 3'd1, 0, 0);

    // Push into a full FIFO coinciding with a pop.
    doReset();
    for (int k = 0; k < 4; k++) sendWord(8'h11 + 8'(k), 1'b1, 1'b0);
    checkOutput("full4", 1, 8'h11, 3'd4, 0, 0);
    sendWord(8'h15, 1'b1, 1'b1);
    checkOutput("push_pop_full", 1, 8'h12, 3'd4, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, 1, 0);
      ew = (k < 3) ? 8'h13 + 8'(k) : 8'h00;
      checkOutput($sformatf("drain_pp%0d", k), k < 3, ew, 3'(3 - k), 0, 0);
    end

    // Asynchronous reset mid-word with words queued.
    doReset();
    sendWord(8'h21, 1'b1, 1'b0);
    sendWord(8'h22, 1'b1, 1'b0);
    pat = 8'h33;
    for (int i = 7; i >= 3; i--) applyStimulus(1, pat[i], i == 7, 0, 0);
    checkOutput("before_async_reset", 1, 8'h21, 3'd2, 0, 0);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset", 0, 8'h00, 3'd0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    sendWord(8'h81, 1'b1, 1'b0);
    checkOutput("after_reset_word", 1, 8'h81, 3'd1, 0, 0);

    // Random traffic against the queue model.
    doReset();
    for (int n = 0; n < 600; n++) begin
      logic bv, b, fr, rdy, clr;
      bv  = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom_range(0, 1));
      fr  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 15) == 0);
      applyStimulus(bv, b, fr, rdy, clr);
      checkOutput($sformatf("rand%0d", n), m_fifo.size() > 0,
                  (m_fifo.size() > 0) ? m_fifo[0] : 8'h00, 3'(m_fifo.size()), m_ovf, m_err);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
